ram_scan_ctrl: RTL

- Parametrised RAM write/scan controller for the board memory labs.
- Writes one word per rising edge of a slide-switch write request.
- Scans all addresses automatically at a slow tick, or reads a user-selected address in manual mode.
- Presents a coherent address/data pair for the HEX display drivers; replaces the fixed 32x8 lab wiring.

---
 rtl/ram_scan_pkg.sv | 23 ++
 rtl/ram_scan_ctrl_if.sv | 27 ++
 rtl/simple_dpram.sv | 27 ++
 rtl/ram_scan_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared sizing helpers and latency constants for the RAM write/scan controller.
// Defaults mirror the original 32x8 lab memory at 50 MHz.
package ram_scan_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 8;
  localparam int TICK_DIV_DEF = 25000000;
  localparam int DEPTH        = 2 ** ADDR_W_DEF;

  // Cycles from the synchronised request edge to wr_ack, and from a
  // manual rd_addr change to disp_data.
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// Switch-side inputs and display-side outputs of the RAM write/scan controller.
// The controller takes the slave view; whoever drives the switches takes master.
interface ram_scan_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              manual;
  logic              pause;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              wr_ack;
  logic              scan_tick;

  modport master (
    output wr_req, wr_addr, wr_data, manual, pause, rd_addr,
    input  disp_addr, disp_data, wr_ack, scan_tick
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, manual, pause, rd_addr,
    output disp_addr, disp_data, wr_ack, scan_tick
  );
endinterface

// File: rtl/simple_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// The array carries no reset so it maps onto plain block RAM.
module simple_dpram
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:depth_of(ADDR_W)-1];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/ram_scan_ctrl.sv
// RAM write/scan controller: edge-triggered switch writes, auto-scan or manual
// reads, and an address/data pair kept aligned for the HEX display drivers.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input logic            CLOCK_50,
  input logic            reset,
  ram_scan_ctrl_if.slave bus
);

  localparam int              CNT_W   = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [1:0]        sync_reg;
  logic              prev_reg;
  logic              req_edge;

  logic              wren_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              wr_ack_reg;

  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              tick_reg;

  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] rd_sel;
  logic [ADDR_W-1:0] raddr_reg;
  logic [ADDR_W-1:0] addr_q_reg;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] disp_addr_reg;
  logic [DATA_W-1:0] disp_data_reg;

  // The switch is asynchronous: two flops to settle it, a third to find the edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], bus.wr_req};
      prev_reg <= sync_reg[1];
    end
  end

  assign req_edge = sync_reg[1] & ~prev_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wren_reg   <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      wr_ack_reg <= 1'b0;
    end else begin
      wren_reg   <= req_edge;
      wr_ack_reg <= wren_reg;
      if (req_edge) begin
        waddr_reg <= bus.wr_addr;
        wdata_reg <= bus.wr_data;
      end
    end
  end

  always_comb begin
    cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
  end

  // The flag is registered from the next count so it is high exactly while
  // cnt_reg sits at its terminal value.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= (cnt_next == CNT_MAX);
    end
  end

  // A committing write wins over a coincident tick so the new word is shown.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (wren_reg) begin
      ptr_reg <= waddr_reg;
    end else if (tick_reg && !bus.manual && !bus.pause) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  always_comb begin
    rd_sel = bus.manual ? bus.rd_addr : ptr_reg;
  end

  simple_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (wren_reg),
    .waddr (waddr_reg),
    .wdata (wdata_reg),
    .raddr (raddr_reg),
    .q     (ram_q)
  );

  // The address travels beside the RAM pipeline so disp_addr always names disp_data.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      raddr_reg     <= '0;
      addr_q_reg    <= '0;
      disp_addr_reg <= '0;
      disp_data_reg <= '0;
    end else begin
      raddr_reg     <= rd_sel;
      addr_q_reg    <= raddr_reg;
      disp_addr_reg <= addr_q_reg;
      disp_data_reg <= ram_q;
    end
  end

  assign bus.disp_addr = disp_addr_reg;
  assign bus.disp_data = disp_data_reg;
  assign bus.wr_ack    = wr_ack_reg;
  assign bus.scan_tick = tick_reg;

endmodule
